// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and state type for the MEM pipeline stage
package pipe_pkg;

   localparam int CTRL_MEM_READ          = 0;
   localparam int CTRL_MEM_WRITE         = 1;
   localparam int CTRL_REG_WRITE         = 2;
   localparam int CTRL_W                 = 14;
   localparam int DEFAULT_TIMEOUT_CYCLES = 16;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

endpackage

// File: rtl/register.sv
// rtl/register.sv - 32-bit enable register with asynchronous active-high clear
module register (
   input  logic        clock,
   input  logic        reset,
   input  logic        en,
   input  logic [31:0] d,
   output logic [31:0] q
);

   // Load d when enabled; reset clears asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM stage: issues data-memory requests, stalls upstream, latches MW results
module mem_stage_ctrl
   import pipe_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       in_PC_next,
   input  logic [31:0]       in_ALU_result,
   input  logic [31:0]       in_data_reg,
   input  logic [CTRL_W-1:0] in_ctrl_signals,
   input  logic [4:0]        in_rd,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [31:0]       dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              stall,
   output logic [31:0]       out_PC_next,
   output logic [31:0]       out_ALU_result,
   output logic [31:0]       out_mem_data,
   output logic [CTRL_W-1:0] out_ctrl_signals,
   output logic [4:0]        out_rd,
   output logic              out_valid,
   output logic              bus_error
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   mem_state_e        state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              capture_en;
   logic              set_error;

   logic [31:0]       cap_pc, cap_alu;
   logic [CTRL_W-1:0] cap_ctrl;
   logic [4:0]        cap_rd;

   logic [31:0]       nxt_pc, nxt_alu, nxt_mem_data;
   logic [CTRL_W-1:0] nxt_ctrl;
   logic [4:0]        nxt_rd;
   logic              nxt_valid;

   logic              in_mem_op;
   logic [31:0]       misc_d, misc_q;

   assign in_mem_op = in_ctrl_signals[CTRL_MEM_READ] | in_ctrl_signals[CTRL_MEM_WRITE];

   // Next state, stall and the value the MW latches take at the next edge (bubble by default).
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      capture_en   = 1'b0;
      set_error    = 1'b0;
      stall        = 1'b0;
      nxt_pc       = '0;
      nxt_alu      = '0;
      nxt_mem_data = '0;
      nxt_ctrl     = '0;
      nxt_rd       = '0;
      nxt_valid    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_mem_op) begin
               stall      = 1'b1;
               state_d    = WAIT;
               capture_en = 1'b1;
               cnt_d      = '0;
            end else begin
               nxt_pc    = in_PC_next;
               nxt_alu   = in_ALU_result;
               nxt_ctrl  = in_ctrl_signals;
               nxt_rd    = in_rd;
               nxt_valid = 1'b1;
            end
         end
         WAIT: begin
            if (dmem_ack) begin
               // Ack beats a simultaneous timeout.
               state_d      = IDLE;
               cnt_d        = '0;
               nxt_pc       = cap_pc;
               nxt_alu      = cap_alu;
               nxt_mem_data = cap_ctrl[CTRL_MEM_WRITE] ? 32'h0 : dmem_rdata;
               nxt_ctrl     = cap_ctrl;
               nxt_rd       = cap_rd;
               nxt_valid    = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               // Give up: release the pipeline and drop the op.
               state_d   = IDLE;
               cnt_d     = '0;
               set_error = 1'b1;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, timeout counter, request and sticky error flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         dmem_req  <= 1'b0;
         bus_error <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dmem_req <= (state_d == WAIT);
         if (set_error)
            bus_error <= 1'b1;
      end
   end

   // Capture the memory op and drive the request fields when entering WAIT.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cap_pc     <= '0;
         cap_alu    <= '0;
         cap_ctrl   <= '0;
         cap_rd     <= '0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else if (capture_en) begin
         cap_pc     <= in_PC_next;
         cap_alu    <= in_ALU_result;
         cap_ctrl   <= in_ctrl_signals;
         cap_rd     <= in_rd;
         dmem_we    <= in_ctrl_signals[CTRL_MEM_WRITE];
         dmem_addr  <= in_ALU_result;
         dmem_wdata <= in_data_reg;
      end
   end

   // Narrow MW fields share one latch: {pad, valid, rd, ctrl}.
   assign misc_d = {12'h0, nxt_valid, nxt_rd, nxt_ctrl};

   register u_pc_reg (
      .clock (clock), .reset (reset), .en (1'b1), .d (nxt_pc), .q (out_PC_next)
   );
   register u_alu_reg (
      .clock (clock), .reset (reset), .en (1'b1), .d (nxt_alu), .q (out_ALU_result)
   );
   register u_mem_data_reg (
      .clock (clock), .reset (reset), .en (1'b1), .d (nxt_mem_data), .q (out_mem_data)
   );
   register u_misc_reg (
      .clock (clock), .reset (reset), .en (1'b1), .d (misc_d), .q (misc_q)
   );

   assign out_ctrl_signals = misc_q[CTRL_W-1:0];
   assign out_rd           = misc_q[CTRL_W+4:CTRL_W];
   assign out_valid        = misc_q[CTRL_W+5];

   wire unused_misc_pad = &{1'b0, misc_q[31:CTRL_W+6]};

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_PC_next = '0, in_ALU_result = '0, in_data_reg = '0;
   logic [13:0] in_ctrl_signals = '0;
   logic [4:0]  in_rd = '0;
   logic        dmem_req, dmem_we, dmem_ack = 1'b0;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
   logic        stall;
   logic [31:0] out_PC_next, out_ALU_result, out_mem_data;
   logic [13:0] out_ctrl_signals;
   logic [4:0]  out_rd;
   logic        out_valid, bus_error;

   int checks = 0;
   int errors = 0;

   mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clock(clock), .reset(reset),
      .in_PC_next(in_PC_next), .in_ALU_result(in_ALU_result), .in_data_reg(in_data_reg),
      .in_ctrl_signals(in_ctrl_signals), .in_rd(in_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
      .out_PC_next(out_PC_next), .out_ALU_result(out_ALU_result), .out_mem_data(out_mem_data),
      .out_ctrl_signals(out_ctrl_signals), .out_rd(out_rd), .out_valid(out_valid),
      .bus_error(bus_error)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [13:0] ctrl, input logic [31:0] alu, input logic [31:0] data,
                        input logic [4:0] rd, input logic [31:0] pc);
      in_ctrl_signals = ctrl;
      in_ALU_result   = alu;
      in_data_reg     = data;
      in_rd           = rd;
      in_PC_next      = pc;
      #1;
   endtask

   task automatic test_reset();
      drive(14'h0, 32'h0, 32'h0, 5'd0, 32'h0);
      tick();
      tick();
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_bus_error: got %b expected 0", bus_error); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      reset = 1'b0;
   endtask

   task automatic test_alu_op();
      drive(14'h004, 32'h1234, 32'h0, 5'd5, 32'h101);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b expected 0", stall); end
      tick();
      checks++; if (out_ALU_result !== 32'h1234) begin errors++; $display("FAIL alu_result: got %h expected 00001234", out_ALU_result); end
      checks++; if (out_rd !== 5'd5) begin errors++; $display("FAIL alu_rd: got %0d expected 5", out_rd); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b expected 1", out_valid); end
      checks++; if (out_PC_next !== 32'h101) begin errors++; $display("FAIL alu_pc: got %h expected 00000101", out_PC_next); end
      checks++; if (out_ctrl_signals !== 14'h004) begin errors++; $display("FAIL alu_ctrl: got %h expected 0004", out_ctrl_signals); end
      checks++; if (out_mem_data !== 32'h0 || dmem_req !== 1'b0) begin errors++; $display("FAIL alu_memdata_req: got %h/%b expected 0/0", out_mem_data, dmem_req); end
   endtask

   // Ack arrives in the 4th WAIT cycle, which is also the final timeout cycle at TIMEOUT_CYCLES=4.
   task automatic test_load_slow_ack();
      int stall_cycles = 0;
      drive(14'h005, 32'h40, 32'h0, 5'd7, 32'h200);
      for (int i = 0; i < 4; i++) begin
         if (stall === 1'b1) stall_cycles++;
         tick();
         checks++; if (out_valid !== 1'b0 || out_rd !== 5'd0) begin errors++; $display("FAIL load_bubble_%0d: got valid=%b rd=%0d expected 0/0", i, out_valid, out_rd); end
      end
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h40) begin errors++; $display("FAIL load_request: got req=%b we=%b addr=%h expected 1/0/00000040", dmem_req, dmem_we, dmem_addr); end
      dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_ack_stall: got %b expected 0", stall); end
      checks++; if (stall_cycles !== 4) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 4", stall_cycles); end
      tick();
      dmem_ack = 1'b0; dmem_rdata = '0;
      drive(14'h000, 32'h0, 32'h0, 5'd0, 32'h0);
      checks++; if (out_mem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: got %h expected deadbeef", out_mem_data); end
      checks++; if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_ALU_result !== 32'h40) begin errors++; $display("FAIL load_result: got valid=%b rd=%0d alu=%h expected 1/7/00000040", out_valid, out_rd, out_ALU_result); end
      checks++; if (dmem_req !== 1'b0 || bus_error !== 1'b0) begin errors++; $display("FAIL load_final_cycle_ack: got req=%b err=%b expected 0/0", dmem_req, bus_error); end
      tick();
      checks++; if (out_rd !== 5'd0 || out_mem_data !== 32'h0) begin errors++; $display("FAIL load_once: got rd=%0d data=%h expected 0/0", out_rd, out_mem_data); end
   endtask

   task automatic test_load_min_latency();
      drive(14'h001, 32'h80, 32'h0, 5'd3, 32'h300);
      tick();
      dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL minlat_stall: got %b expected 0", stall); end
      tick();
      dmem_ack = 1'b0; dmem_rdata = '0;
      drive(14'h000, 32'h0, 32'h0, 5'd0, 32'h0);
      checks++; if (out_mem_data !== 32'h11223344 || out_valid !== 1'b1 || out_rd !== 5'd3) begin errors++; $display("FAIL minlat_result: got data=%h valid=%b rd=%0d expected 11223344/1/3", out_mem_data, out_valid, out_rd); end
   endtask

   task automatic test_store(input logic [13:0] ctrl);
      drive(ctrl, 32'h10, 32'hA5, 5'd0, 32'h400);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL store_%h_stall: got %b expected 1", ctrl, stall); end
      tick();
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h10 || dmem_wdata !== 32'hA5) begin errors++; $display("FAIL store_%h_request: got req=%b we=%b addr=%h wdata=%h expected 1/1/00000010/000000a5", ctrl, dmem_req, dmem_we, dmem_addr, dmem_wdata); end
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
      tick();
      dmem_ack = 1'b0; dmem_rdata = '0;
      drive(14'h000, 32'h0, 32'h0, 5'd0, 32'h0);
      checks++; if (out_mem_data !== 32'h0 || out_valid !== 1'b1 || out_ctrl_signals !== ctrl) begin errors++; $display("FAIL store_%h_result: got data=%h valid=%b ctrl=%h expected 0/1/%h", ctrl, out_mem_data, out_valid, out_ctrl_signals, ctrl); end
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      drive(14'h001, 32'h44, 32'h0, 5'd6, 32'h500);
      tick();
      for (int i = 0; i < 4; i++) begin
         if (dmem_req === 1'b1) req_cycles++;
         checks++; if (stall !== (i < 3)) begin errors++; $display("FAIL timeout_stall_%0d: got %b expected %b", i, stall, (i < 3)); end
         tick();
      end
      checks++; if (req_cycles !== 4 || dmem_req !== 1'b0) begin errors++; $display("FAIL timeout_req: got cycles=%0d req=%b expected 4/0", req_cycles, dmem_req); end
      checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL timeout_bus_error: got %b expected 1", bus_error); end
      checks++; if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_ALU_result !== 32'h0) begin errors++; $display("FAIL timeout_bubble: got valid=%b rd=%0d alu=%h expected 0/0/0", out_valid, out_rd, out_ALU_result); end
      drive(14'h004, 32'h55, 32'h0, 5'd9, 32'h600);
      dmem_ack = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL after_timeout_stall: got %b expected 0", stall); end
      tick();
      dmem_ack = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_rd !== 5'd9 || out_ALU_result !== 32'h55 || dmem_req !== 1'b0) begin errors++; $display("FAIL after_timeout_alu: got valid=%b rd=%0d alu=%h req=%b expected 1/9/00000055/0", out_valid, out_rd, out_ALU_result, dmem_req); end
      checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL bus_error_sticky: got %b expected 1", bus_error); end
   endtask

   task automatic test_reset_mid_wait();
      drive(14'h001, 32'h99, 32'h0, 5'd4, 32'h700);
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      checks++; if (dmem_req !== 1'b0 || dmem_addr !== 32'h0) begin errors++; $display("FAIL midwait_req: got req=%b addr=%h expected 0/0", dmem_req, dmem_addr); end
      checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL midwait_bus_error: got %b expected 0", bus_error); end
      checks++; if (out_valid !== 1'b0 || out_PC_next !== 32'h0 || out_ALU_result !== 32'h0 || out_ctrl_signals !== 14'h0) begin errors++; $display("FAIL midwait_outputs: got valid=%b pc=%h alu=%h ctrl=%h expected all 0", out_valid, out_PC_next, out_ALU_result, out_ctrl_signals); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midwait_stall_idle_rule: got %b expected 1", stall); end
      tick();
      drive(14'h004, 32'h77, 32'h0, 5'd2, 32'h800);
      reset = 1'b0;
      #1;
      tick();
      checks++; if (out_valid !== 1'b1 || out_ALU_result !== 32'h77 || out_rd !== 5'd2) begin errors++; $display("FAIL post_reset_first_edge: got valid=%b alu=%h rd=%0d expected 1/00000077/2", out_valid, out_ALU_result, out_rd); end
   endtask

   initial begin
      test_reset();
      test_alu_op();
      test_load_slow_ack();
      test_load_min_latency();
      test_store(14'h002);
      test_store(14'h003);
      test_timeout();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max WAIT cycles before abort (range 2..255).
REQ-002 SHALL have port clock, in, 1: single clock, rising edge.
REQ-003 SHALL have port reset, in, 1: asynchronous, active-high.
REQ-004 SHALL have port in_PC_next, in, 32: PC+1 from XM latch output.
REQ-005 SHALL have port in_ALU_result, in, 32: effective address / ALU value from XM latch.
REQ-006 SHALL have port in_data_reg, in, 32: store data from XM latch.
REQ-007 SHALL have port in_ctrl_signals, in, 14: XM control word; bit0 mem_read, bit1 mem_write, bit2 reg_write.
REQ-008 SHALL have port in_rd, in, 5: destination register from XM latch.
REQ-009 SHALL have port dmem_req, out, 1: registered memory request.
REQ-010 SHALL have port dmem_we, out, 1: write enable, valid with dmem_req.
REQ-011 SHALL have port dmem_addr, out, 32: registered address.
REQ-012 SHALL have port dmem_wdata, out, 32: registered store data.
REQ-013 SHALL have port dmem_ack, in, 1: one-cycle completion pulse.
REQ-014 SHALL have port dmem_rdata, in, 32: load data, valid when dmem_ack=1.
REQ-015 SHALL have port stall, out, 1: combinational; upstream drives XM wren = ~stall.
REQ-016 SHALL have ports out_PC_next (32), out_ALU_result (32), out_mem_data (32), out_ctrl_signals (14), out_rd (5), out_valid (1), all out: registered MW-side results.
REQ-017 SHALL have port bus_error, out, 1: sticky timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT.
REQ-019 IDLE, no memory op (bit0=bit1=0): outputs load inputs at next edge, out_mem_data=0, out_valid=1, stall=0; latency 1.
REQ-020 IDLE, memory op: stall=1 that cycle; next edge -> WAIT, dmem_req=1, dmem_we=bit1, dmem_addr=in_ALU_result, dmem_wdata=in_data_reg, inputs captured internally; outputs load bubble.
REQ-021 Both bit0 and bit1 set SHALL be treated as a store.
REQ-022 WAIT, dmem_ack=0: stall=1, dmem_req held, timeout counter increments; outputs load bubble each edge.
REQ-023 WAIT, dmem_ack=1: stall=0 same cycle; next edge -> IDLE, dmem_req=0, counter cleared, outputs load captured op, out_mem_data=dmem_rdata for load, 0 for store, out_valid=1.
REQ-024 Bubble SHALL be out_ctrl_signals=0, out_rd=0, out_valid=0, data outputs 0.
REQ-025 WAIT with counter=TIMEOUT_CYCLES-1 and no ack: stall=0; next edge -> IDLE, dmem_req=0, bus_error=1, outputs load bubble (op dropped).
REQ-026 Ack and timeout in same cycle: ack wins, no bus_error.
REQ-027 dmem_ack while IDLE SHALL be ignored.
REQ-028 bus_error SHALL remain 1 until reset.
REQ-029 Minimum memory-op latency SHALL be 2 cycles (ack in first WAIT cycle).

Reset
REQ-030 Reset asserted (any time, incl. mid-WAIT) SHALL asynchronously force IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, all out_* =0, bus_error=0; stall then follows IDLE rule from inputs.
REQ-031 First edge after reset release SHALL follow IDLE rules.

Structure
REQ-032 Package pipe_pkg SHALL hold CTRL_MEM_READ=0, CTRL_MEM_WRITE=1, CTRL_REG_WRITE=2, CTRL_W=14, state enum, default TIMEOUT_CYCLES.
REQ-033 Output latches SHALL use the existing 32-bit enable register sub-module (register), enable tied high, narrow fields zero-padded.
REQ-034 Timeout counter SHALL be 8 bits.

Verification
REQ-035 ALU op ctrl=0x004, rd=5, ALU=0x1234 -> next edge out_ALU_result=0x1234, out_rd=5, out_valid=1, stall never 1.
REQ-036 Load ctrl=0x005, addr=0x40, ack 3 cycles after WAIT entry with rdata=0xDEADBEEF -> stall high 4 cycles, out_mem_data=0xDEADBEEF, out_rd valid once.
REQ-037 Store ctrl=0x002, addr=0x10, data=0xA5 -> dmem_we=1, dmem_addr=0x10, dmem_wdata=0xA5, after ack out_mem_data=0, out_valid=1.
REQ-038 Load, no ack, TIMEOUT_CYCLES=4 -> dmem_req high 4 cycles, bus_error=1, bubble output, next ALU op proceeds normally.
REQ-039 Reset asserted mid-WAIT -> dmem_req=0 and outputs 0 immediately (before next edge), bus_error=0.
REQ-040 Ack on final timeout cycle -> load completes, bus_error stays 0.
